// File: rtl/mux_somador_acumulador_param_if.sv
// Operand/result bundle for the mux/adder/accumulator stage.
// The master drives the operand channels; the slave returns the result and flags.
interface mux_somador_acumulador_param_if #(
   parameter int WIDTH  = 4,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN),
   parameter int CNT_W  = 8
);
   logic [NUM_IN*WIDTH-1:0] IN_DATA;
   logic [SEL_W-1:0]        SEL;
   logic [WIDTH-1:0]        C;
   logic [1:0]              MODE;
   logic                    SAT;
   logic                    IN_VALID;
   logic [WIDTH-1:0]        RES;
   logic                    OUT_VALID;
   logic                    CARRY;
   logic                    OVF;
   logic [CNT_W-1:0]        ACC_CNT;

   modport master (
      output IN_DATA, SEL, C, MODE, SAT, IN_VALID,
      input  RES, OUT_VALID, CARRY, OVF, ACC_CNT
   );

   modport slave (
      input  IN_DATA, SEL, C, MODE, SAT, IN_VALID,
      output RES, OUT_VALID, CARRY, OVF, ACC_CNT
   );
endinterface

// File: rtl/mux_somador_acumulador_param.sv
// Two-stage select/add/accumulate/subtract ALU with wrap or saturate per beat,
// global stall, carry, sticky overflow and a saturating ACC-run counter.
module mux_somador_acumulador_param #(
   parameter int WIDTH  = 4,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN),
   parameter int CNT_W  = 8
) (
   input  logic CLK,
   input  logic RESET,
   input  logic ENABLE,
   mux_somador_acumulador_param_if.slave bus
);
   typedef enum logic [1:0] {
      M_ADD = 2'b00,
      M_ACC = 2'b01,
      M_SUB = 2'b10,
      M_CLR = 2'b11
   } mode_e;

   typedef struct packed {
      logic [WIDTH-1:0] op;
      logic [WIDTH-1:0] c;
      mode_e            mode;
      logic             sat;
   } beat_t;

   // bit 0 = stage-1 valid, bit 1 = OUT_VALID
   logic [1:0]       vld_pipe_q, vld_pipe_d;
   beat_t            s1_q, s1_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] op_sel;
   logic [WIDTH:0]   raw;

   // Out-of-range selects fall through to zero.
   always_comb begin
      op_sel = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (int'(bus.SEL) == k) op_sel = bus.IN_DATA[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      vld_pipe_d = vld_pipe_q;
      s1_d       = s1_q;
      if (ENABLE) begin
         vld_pipe_d = {vld_pipe_q[0], bus.IN_VALID};
         if (bus.IN_VALID) begin
            s1_d.op   = op_sel;
            s1_d.c    = bus.C;
            s1_d.mode = mode_e'(bus.MODE);
            s1_d.sat  = bus.SAT;
         end
      end
   end

   // ACC feeds back from res_q directly, so back-to-back ACC beats chain with no bubble.
   always_comb begin
      case (s1_q.mode)
         M_ADD:   raw = {1'b0, s1_q.op} + {1'b0, s1_q.c};
         M_ACC:   raw = {1'b0, res_q}   + {1'b0, s1_q.op};
         M_SUB:   raw = {1'b0, s1_q.op} - {1'b0, s1_q.c};
         default: raw = '0;
      endcase
   end

   always_comb begin
      res_d   = res_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      if (ENABLE && vld_pipe_q[0]) begin
         carry_d = raw[WIDTH];
         ovf_d   = ovf_q | raw[WIDTH];
         if (s1_q.sat && raw[WIDTH])
            res_d = (s1_q.mode == M_SUB) ? '0 : '1;
         else
            res_d = raw[WIDTH-1:0];
         case (s1_q.mode)
            M_ACC: cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            M_CLR: begin
               res_d   = '0;
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
            end
            default: cnt_d = '0;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         vld_pipe_q <= '0;
         s1_q       <= '0;
         res_q      <= '0;
         carry_q    <= 1'b0;
         ovf_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         s1_q       <= s1_d;
         res_q      <= res_d;
         carry_q    <= carry_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.RES       = res_q;
   assign bus.OUT_VALID = vld_pipe_q[1];
   assign bus.CARRY     = carry_q;
   assign bus.OVF       = ovf_q;
   assign bus.ACC_CNT   = cnt_q;
endmodule
